// File: rtl/lc3_mem_pkg.sv
// Shared constants and types for the LC-3 memory subsystem.
package lc3_pkg;

  // Memory-mapped I/O register addresses (full 16-bit match).
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  // Access sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // True when a (zero-extended) address equals one of the I/O registers.
  function automatic logic addr_is(input logic [31:0] a, input logic [15:0] reg_addr);
    return a == {16'h0000, reg_addr};
  endfunction

endpackage

// File: rtl/lc3_mem_io.sv
// Keyboard/display register block: KBSR/KBDR/DSR/DDR decode and side effects.
module lc3_mem_io
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              hit,
  output logic [DATA_W-1:0] rdata,
  input  logic              kb_valid,
  input  logic [7:0]        kb_char,
  output logic              kb_ack,
  input  logic              disp_ready,
  output logic              disp_valid,
  output logic [7:0]        disp_char
);

  logic       kb_full;
  logic [7:0] kbdr;
  logic       sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
  logic       kb_clr, kb_take, disp_fire;

  // Address decode, read mux and event qualification.
  always_comb begin
    sel_kbsr = addr_is(32'(addr), KBSR_ADDR);
    sel_kbdr = addr_is(32'(addr), KBDR_ADDR);
    sel_dsr  = addr_is(32'(addr), DSR_ADDR);
    sel_ddr  = addr_is(32'(addr), DDR_ADDR);
    hit      = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr;

    rdata = '0;
    if (sel_kbsr)      rdata[15]  = kb_full;
    else if (sel_kbdr) rdata[7:0] = kbdr;
    else if (sel_dsr)  rdata[15]  = disp_ready;

    // A completing KBDR read clears kb_full and blocks a same-cycle capture;
    // the capture then happens the following cycle if kb_valid persists.
    kb_clr    = done && !we && sel_kbdr;
    kb_take   = kb_valid && !kb_full && !kb_clr;
    disp_fire = done && we && sel_ddr && disp_ready;
  end

  // Keyboard and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_full    <= 1'b0;
      kbdr       <= '0;
      kb_ack     <= 1'b0;
      disp_valid <= 1'b0;
      disp_char  <= '0;
    end else begin
      if (kb_clr)       kb_full <= 1'b0;
      else if (kb_take) kb_full <= 1'b1;
      if (kb_take)      kbdr    <= kb_char;
      kb_ack     <= kb_take;
      disp_valid <= disp_fire;
      if (disp_fire)    disp_char <= wdata;
    end
  end

endmodule

// File: rtl/lc3_mem.sv
// LC-3 memory subsystem: latency-configurable RAM with ready handshake and
// optional memory-mapped keyboard/display registers.
module lc3_mem
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2 ** ADDR_W,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1,
  parameter int unsigned IO_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  input  logic              kb_valid,
  input  logic [7:0]        kb_char,
  output logic              kb_ack,
  input  logic              disp_ready,
  output logic              disp_valid,
  output logic [7:0]        disp_char
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  logic [DATA_W-1:0] mem [DEPTH];

  mem_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, lat;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] data_q;
  logic              hold, hold_nxt;
  logic              accept, done;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [DATA_W-1:0] acc_data;
  logic [IDX_W-1:0]  idx;
  logic              io_hit;
  logic [DATA_W-1:0] io_rdata;

  // Next-state, completion and access-operand selection.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    done      = 1'b0;
    acc_addr  = addr_q;
    acc_we    = we_q;
    acc_data  = data_q;
    lat       = we ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);

    unique case (state)
      IDLE: begin
        if (mem_en && !hold) begin
          accept   = 1'b1;
          // Single-cycle accesses complete straight from IDLE using live inputs.
          acc_addr = addr;
          acc_we   = we;
          acc_data = data;
          if (lat <= CNT_W'(1)) begin
            done = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = lat - CNT_W'(1);
          end
        end
      end
      BUSY: begin
        if (!mem_en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // After a completion mem_en must be seen low before another request.
    if (done)         hold_nxt = 1'b1;
    else if (!mem_en) hold_nxt = 1'b0;
    else              hold_nxt = hold;

    idx = IDX_W'(32'(acc_addr) % DEPTH);
  end

  // Sequencer state, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
      data_q <= '0;
      hold   <= 1'b0;
      ready  <= 1'b0;
      rdata  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hold  <= hold_nxt;
      ready <= done;
      if (accept) begin
        addr_q <= addr;
        we_q   <= we;
        data_q <= data;
      end
      if (done && !acc_we) rdata <= io_hit ? io_rdata : mem[idx];
    end
  end

  // Storage write port; contents are not reset and writes never commit in reset.
  always_ff @(posedge clk) begin
    if (rst_n && done && acc_we && !io_hit) mem[idx] <= acc_data;
  end

  if (IO_EN != 0) begin : g_io
    lc3_mem_io #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_io (
      .clk        (clk),
      .rst_n      (rst_n),
      .done       (done),
      .we         (acc_we),
      .addr       (acc_addr),
      .wdata      (acc_data[7:0]),
      .hit        (io_hit),
      .rdata      (io_rdata),
      .kb_valid   (kb_valid),
      .kb_char    (kb_char),
      .kb_ack     (kb_ack),
      .disp_ready (disp_ready),
      .disp_valid (disp_valid),
      .disp_char  (disp_char)
    );
  end else begin : g_no_io
    logic unused_io;
    assign unused_io  = ^{kb_valid, kb_char, disp_ready};
    assign io_hit     = 1'b0;
    assign io_rdata   = '0;
    assign kb_ack     = 1'b0;
    assign disp_valid = 1'b0;
    assign disp_char  = '0;
  end

endmodule

// File: tb/tb_lc3_mem.sv
// Directed bench for lc3_mem: default instance (RD_LAT 2, WR_LAT 1, I/O on)
// and a small instance (DEPTH 256, latency 4, I/O off).
module tb_lc3_mem;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_en, a_we, a_ready, a_kb_valid, a_kb_ack, a_disp_ready, a_disp_valid;
  logic [15:0] a_addr, a_data, a_rdata;
  logic [7:0]  a_kb_char, a_disp_char;
  // Instance B signals
  logic        b_en, b_we, b_ready, b_kb_ack, b_disp_valid;
  logic [15:0] b_addr, b_data, b_rdata;
  logic [7:0]  b_disp_char;

  int tests = 0;
  int fails = 0;
  logic        last_dv;
  logic [7:0]  last_dc;
  logic [15:0] rd;
  int          cyc;
  int          pulses;

  lc3_mem #(
    .ADDR_W(16), .DATA_W(16), .DEPTH(65536), .RD_LAT(2), .WR_LAT(1), .IO_EN(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .mem_en(a_en), .we(a_we), .addr(a_addr), .data(a_data),
    .rdata(a_rdata), .ready(a_ready), .kb_valid(a_kb_valid), .kb_char(a_kb_char),
    .kb_ack(a_kb_ack), .disp_ready(a_disp_ready), .disp_valid(a_disp_valid),
    .disp_char(a_disp_char)
  );

  lc3_mem #(
    .ADDR_W(16), .DATA_W(16), .DEPTH(256), .RD_LAT(4), .WR_LAT(4), .IO_EN(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .mem_en(b_en), .we(b_we), .addr(b_addr), .data(b_data),
    .rdata(b_rdata), .ready(b_ready), .kb_valid(1'b1), .kb_char(8'h55),
    .kb_ack(b_kb_ack), .disp_ready(1'b1), .disp_valid(b_disp_valid),
    .disp_char(b_disp_char)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic acc_a(input logic w, input logic [15:0] ad, input logic [15:0] dt,
                       output logic [15:0] r, output int c);
    @(negedge clk);
    a_en = 1'b1; a_we = w; a_addr = ad; a_data = dt;
    c = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (a_ready) begin c = i; break; end
    end
    r = a_rdata; last_dv = a_disp_valid; last_dc = a_disp_char;
    a_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic acc_b(input logic w, input logic [15:0] ad, input logic [15:0] dt,
                       output logic [15:0] r, output int c);
    @(negedge clk);
    b_en = 1'b1; b_we = w; b_addr = ad; b_data = dt;
    c = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (b_ready) begin c = i; break; end
    end
    r = b_rdata;
    b_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 0; a_we = 0; a_addr = '0; a_data = '0;
    a_kb_valid = 0; a_kb_char = '0; a_disp_ready = 0;
    b_en = 0; b_we = 0; b_addr = '0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", 32'(a_rdata), 32'h0);
    check("rst_ready", 32'(a_ready), 32'h0);
    check("rst_kb_ack", 32'(a_kb_ack), 32'h0);
    check("rst_disp", 32'({a_disp_valid, a_disp_char}), 32'h0);
    check("rst_b_out", 32'({b_ready, b_rdata, b_kb_ack, b_disp_valid, b_disp_char}), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Preload and read with RD_LAT=2
    acc_a(1'b1, 16'h3000, 16'h1234, rd, cyc);
    check("wr_lat1", 32'(cyc), 32'd1);
    acc_a(1'b0, 16'h3000, 16'h0, rd, cyc);
    check("rd_lat2", 32'(cyc), 32'd2);
    check("rd_3000", 32'(rd), 32'h1234);

    acc_a(1'b1, 16'h0010, 16'hBEEF, rd, cyc);
    acc_a(1'b0, 16'h0010, 16'h0, rd, cyc);
    check("rd_0010", 32'(rd), 32'hBEEF);

    // Back-to-back with one idle cycle between
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_en = (c == 0 || c == 2); a_we = 1'b1;
      a_addr = (c < 2) ? 16'h0020 : 16'h0021;
      a_data = (c < 2) ? 16'h1111 : 16'h2222;
      @(posedge clk); #1;
      if (a_ready) pulses++;
    end
    check("b2b_pulses", 32'(pulses), 32'd2);
    acc_a(1'b0, 16'h0021, 16'h0, rd, cyc);
    check("rd_0021", 32'(rd), 32'h2222);

    // mem_en held high past ready is a single request
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_en = (c < 4); a_we = 1'b1; a_addr = 16'h0022; a_data = 16'h3333;
      @(posedge clk); #1;
      if (a_ready) pulses++;
    end
    check("hold_pulses", 32'(pulses), 32'd1);

    // Address wrap on DEPTH=256, latency 4
    acc_b(1'b1, 16'h0105, 16'hAAAA, rd, cyc);
    check("b_wr_lat4", 32'(cyc), 32'd4);
    acc_b(1'b0, 16'h0005, 16'h0, rd, cyc);
    check("b_rd_lat4", 32'(cyc), 32'd4);
    check("wrap_0005", 32'(rd), 32'hAAAA);

    // Abort: write dropped after 2 cycles leaves memory unchanged
    acc_b(1'b1, 16'h0030, 16'hCAFE, rd, cyc);
    @(negedge clk);
    b_en = 1'b1; b_we = 1'b1; b_addr = 16'h0030; b_data = 16'h1111;
    pulses = 0;
    repeat (2) begin @(posedge clk); #1; if (b_ready) pulses++; end
    @(negedge clk); b_en = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (b_ready) pulses++; end
    check("abort_ready", 32'(pulses), 32'd0);
    acc_b(1'b0, 16'h0030, 16'h0, rd, cyc);
    check("abort_mem", 32'(rd), 32'hCAFE);

    // Keyboard capture and register reads
    @(negedge clk); a_kb_valid = 1'b1; a_kb_char = 8'h41;
    @(posedge clk); #1;
    check("kb_ack_pulse", 32'(a_kb_ack), 32'h1);
    @(negedge clk); a_kb_valid = 1'b0;
    @(posedge clk); #1;
    check("kb_ack_drop", 32'(a_kb_ack), 32'h0);
    acc_a(1'b0, 16'hFE00, 16'h0, rd, cyc);
    check("kbsr_full", 32'(rd), 32'h8000);
    acc_a(1'b0, 16'hFE02, 16'h0, rd, cyc);
    check("kbdr_41", 32'(rd), 32'h0041);
    acc_a(1'b0, 16'hFE00, 16'h0, rd, cyc);
    check("kbsr_clear", 32'(rd), 32'h0000);

    // KBDR-read completion coinciding with a capture: clear wins, capture next cycle
    @(negedge clk); a_en = 1'b1; a_we = 1'b0; a_addr = 16'hFE02;
    @(posedge clk); #1;
    @(negedge clk); a_kb_valid = 1'b1; a_kb_char = 8'h5A;
    @(posedge clk); #1;
    check("sim_ready", 32'(a_ready), 32'h1);
    check("sim_rdata", 32'(a_rdata), 32'h0041);
    check("sim_no_ack", 32'(a_kb_ack), 32'h0);
    @(negedge clk); a_en = 1'b0;
    @(posedge clk); #1;
    check("sim_late_ack", 32'(a_kb_ack), 32'h1);
    @(negedge clk); a_kb_valid = 1'b0;
    acc_a(1'b0, 16'hFE00, 16'h0, rd, cyc);
    check("kbsr_full2", 32'(rd), 32'h8000);
    acc_a(1'b0, 16'hFE02, 16'h0, rd, cyc);
    check("kbdr_5a", 32'(rd), 32'h005A);

    // Display
    a_disp_ready = 1'b1;
    acc_a(1'b1, 16'hFE06, 16'h0048, rd, cyc);
    check("ddr_valid", 32'(last_dv), 32'h1);
    check("ddr_char", 32'(last_dc), 32'h48);
    a_disp_ready = 1'b0;
    acc_a(1'b1, 16'hFE06, 16'h0065, rd, cyc);
    check("ddr_drop_valid", 32'(last_dv), 32'h0);
    check("ddr_drop_char", 32'(last_dc), 32'h48);
    acc_a(1'b0, 16'hFE04, 16'h0, rd, cyc);
    check("dsr_low", 32'(rd), 32'h0000);
    a_disp_ready = 1'b1;
    acc_a(1'b0, 16'hFE04, 16'h0, rd, cyc);
    check("dsr_high", 32'(rd), 32'h8000);

    // Reset mid-operation: read on A, write on B
    @(negedge clk);
    a_en = 1'b1; a_we = 1'b0; a_addr = 16'h3000;
    b_en = 1'b1; b_we = 1'b1; b_addr = 16'h0030; b_data = 16'h2222;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(a_ready), 32'h0);
    check("mid_rst_rdata", 32'(a_rdata), 32'h0);
    check("mid_rst_disp", 32'({a_disp_valid, a_disp_char}), 32'h0);
    pulses = 0;
    repeat (3) begin @(posedge clk); #1; if (a_ready || b_ready) pulses++; end
    check("mid_rst_pulses", 32'(pulses), 32'd0);
    @(negedge clk); a_en = 1'b0; b_en = 1'b0; rst_n = 1'b1;
    acc_b(1'b0, 16'h0030, 16'h0, rd, cyc);
    check("rst_no_write", 32'(rd), 32'hCAFE);
    acc_a(1'b0, 16'h3000, 16'h0, rd, cyc);
    check("mem_kept", 32'(rd), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
